// File: rtl/sdrc_req_arb_if.sv
// Bundles the master-side request/data signals and the converter-side request port of
// sdrc_req_arb. The arbiter connects through the slave modport; the environment uses master.
interface sdrc_req_arb_if #(
  parameter int NREQ   = 2,
  parameter int APP_AW = 30,
  parameter int APP_DW = 32,
  parameter int APP_BW = 4,
  parameter int APP_RW = 9
);
  logic [NREQ-1:0]        m_req;
  logic [NREQ*APP_AW-1:0] m_req_addr;
  logic [NREQ*APP_RW-1:0] m_req_len;
  logic [NREQ-1:0]        m_req_wr_n;
  logic [NREQ-1:0]        m_req_dma_last;
  logic [NREQ*APP_DW-1:0] m_wr_data;
  logic [NREQ*APP_BW-1:0] m_wr_en_n;
  logic [NREQ-1:0]        m_req_ack;
  logic [NREQ-1:0]        m_wr_next;
  logic [NREQ-1:0]        m_rd_valid;
  logic [APP_DW-1:0]      m_rd_data;

  logic                   app_sdr_req;
  logic [APP_AW-1:0]      app_req_addr;
  logic [APP_RW-1:0]      app_req_len;
  logic                   app_req_wr_n;
  logic                   app_req_dma_last;
  logic                   app_req_ack;
  logic [APP_DW-1:0]      app_wr_data;
  logic [APP_BW-1:0]      app_wr_en_n;
  logic                   app_wr_next;
  logic [APP_DW-1:0]      app_rd_data;
  logic                   app_rd_valid;

  modport slave (
    input  m_req, m_req_addr, m_req_len, m_req_wr_n, m_req_dma_last, m_wr_data, m_wr_en_n,
    input  app_req_ack, app_wr_next, app_rd_data, app_rd_valid,
    output m_req_ack, m_wr_next, m_rd_valid, m_rd_data,
    output app_sdr_req, app_req_addr, app_req_len, app_req_wr_n, app_req_dma_last,
    output app_wr_data, app_wr_en_n
  );

  modport master (
    output m_req, m_req_addr, m_req_len, m_req_wr_n, m_req_dma_last, m_wr_data, m_wr_en_n,
    output app_req_ack, app_wr_next, app_rd_data, app_rd_valid,
    input  m_req_ack, m_wr_next, m_rd_valid, m_rd_data,
    input  app_sdr_req, app_req_addr, app_req_len, app_req_wr_n, app_req_dma_last,
    input  app_wr_data, app_wr_en_n
  );
endinterface

// File: rtl/sdrc_req_arb.sv
// Arbitrates NREQ application masters onto one SDRAM request port, holding the grant for a
// whole request+data transaction. Define SDRC_ARB_FIXED_PRIO_EN for fixed priority (master 0 first).
module sdrc_req_arb #(
  parameter int NREQ   = 2,
  parameter int APP_AW = 30,
  parameter int APP_DW = 32,
  parameter int APP_BW = 4,
  parameter int APP_RW = 9
) (
  input  logic          clk,
  input  logic          reset,
  sdrc_req_arb_if.slave io_bus
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WDATA, S_RDATA} state_t;

  state_t            r_state;
  logic [GW-1:0]     r_gnt;
  logic [GW-1:0]     r_last;
  logic [APP_RW-1:0] r_beat_cnt;
  logic [GW-1:0]     w_winner;
  logic [NREQ-1:0]   w_gnt_oh;

  logic [APP_AW-1:0] w_addr  [NREQ];
  logic [APP_RW-1:0] w_len   [NREQ];
  logic [APP_DW-1:0] w_wdata [NREQ];
  logic [APP_BW-1:0] w_ben   [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_addr[gi]  = io_bus.m_req_addr[gi*APP_AW +: APP_AW];
    assign w_len[gi]   = io_bus.m_req_len[gi*APP_RW +: APP_RW];
    assign w_wdata[gi] = io_bus.m_wr_data[gi*APP_DW +: APP_DW];
    assign w_ben[gi]   = io_bus.m_wr_en_n[gi*APP_BW +: APP_BW];
  end

  // Scan starts just after the previous owner so every requester gets a turn.
  function automatic logic [GW-1:0] pick_rr(input logic [NREQ-1:0] req, input logic [GW-1:0] last);
    logic [GW-1:0]   win;
    logic            found;
    logic [NREQ-1:0] sh;
    int              idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      sh  = req >> idx;
      if (!found && sh[0]) begin
        win   = GW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [GW-1:0] pick_fixed(input logic [NREQ-1:0] req);
    logic [GW-1:0]   win;
    logic [NREQ-1:0] sh;
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sh = req >> k;
      if (sh[0]) win = GW'(k);
    end
    return win;
  endfunction

`ifdef SDRC_ARB_FIXED_PRIO_EN
  assign w_winner = pick_fixed(io_bus.m_req);
`else
  assign w_winner = pick_rr(io_bus.m_req, r_last);
`endif

  assign w_gnt_oh = NREQ'(1) << r_gnt;

  always_comb begin
    io_bus.app_sdr_req      = (r_state == S_REQ);
    io_bus.app_req_addr     = '0;
    io_bus.app_req_len      = '0;
    io_bus.app_req_wr_n     = 1'b1;
    io_bus.app_req_dma_last = 1'b0;
    if (r_state == S_REQ) begin
      io_bus.app_req_addr     = w_addr[r_gnt];
      io_bus.app_req_len      = w_len[r_gnt];
      io_bus.app_req_wr_n     = io_bus.m_req_wr_n[r_gnt];
      io_bus.app_req_dma_last = io_bus.m_req_dma_last[r_gnt];
    end
    io_bus.app_wr_data = w_wdata[r_gnt];
    io_bus.app_wr_en_n = (r_state == S_WDATA) ? w_ben[r_gnt] : '1;
    // Strobes reach only the owner, and only in the state that expects them.
    io_bus.m_req_ack   = (r_state == S_REQ   && io_bus.app_req_ack)  ? w_gnt_oh : '0;
    io_bus.m_wr_next   = (r_state == S_WDATA && io_bus.app_wr_next)  ? w_gnt_oh : '0;
    io_bus.m_rd_valid  = (r_state == S_RDATA && io_bus.app_rd_valid) ? w_gnt_oh : '0;
    io_bus.m_rd_data   = io_bus.app_rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_last     <= GW'(NREQ - 1);
      r_beat_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|io_bus.m_req) begin
            r_gnt   <= w_winner;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack in the same cycle as the request dropping still completes the grant.
          if (io_bus.app_req_ack) begin
            r_last     <= r_gnt;
            r_beat_cnt <= w_len[r_gnt];
            if (w_len[r_gnt] == '0)
              r_state <= S_IDLE;
            else if (!io_bus.m_req_wr_n[r_gnt])
              r_state <= S_WDATA;
            else
              r_state <= S_RDATA;
          end else if (!io_bus.m_req[r_gnt]) begin
            r_state <= S_IDLE;
          end
        end
        S_WDATA: begin
          if (io_bus.app_wr_next) begin
            if (r_beat_cnt != '0) r_beat_cnt <= r_beat_cnt - APP_RW'(1);
            if (r_beat_cnt <= APP_RW'(1)) r_state <= S_IDLE;
          end
        end
        S_RDATA: begin
          if (io_bus.app_rd_valid) begin
            if (r_beat_cnt != '0) r_beat_cnt <= r_beat_cnt - APP_RW'(1);
            if (r_beat_cnt <= APP_RW'(1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
